// File: rtl/reorder_buffer_pkg.sv
// ------------------------------------------------------------------
// reorder_buffer_pkg : entry layout and shared ROB constants
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package reorder_buffer_pkg;
  localparam int c_DEF_ROB_ENTRY  = 4;
  localparam int c_DEF_ARCH_ENTRY = 32;
  localparam int c_DEF_DATA_WIDTH = 32;
  localparam int c_DEF_LSN_PORTS  = 4;

  // Per-entry status flags, packed into one small vector per entry
  localparam int c_FLAG_VALID = 0;
  localparam int c_FLAG_DONE  = 1;
  localparam int c_FLAG_W     = 2;

  localparam int c_X0_IDX = 0;
endpackage

`default_nettype wire

// File: rtl/rob_lsn_port.sv
// ------------------------------------------------------------------
// rob_lsn_port : single listen-port lookup with CDB writeback bypass
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module rob_lsn_port
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_ENTRY      = c_DEF_ROB_ENTRY,
  parameter int DATA_WIDTH     = c_DEF_DATA_WIDTH,
  parameter int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) (
  input  logic                           request,
  input  logic [ROB_ENTRY_LOG2-1:0]      id,
  input  logic                           wb_valid,
  input  logic [ROB_ENTRY_LOG2-1:0]      wb_id,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic [ROB_ENTRY-1:0]           entry_valid,
  input  logic [ROB_ENTRY-1:0]           entry_done,
  input  logic [ROB_ENTRY*DATA_WIDTH-1:0] entry_data,
  output logic                           hit,
  output logic [DATA_WIDTH-1:0]          data
);

  always_comb begin
    hit  = 1'b0;
    data = entry_data[int'(id)*DATA_WIDTH +: DATA_WIDTH];
    // A result on the CDB this cycle wins over the stored copy
    if (wb_valid && (wb_id == id) && entry_valid[id]) begin
      hit  = request;
      data = wb_data;
    end else begin
      hit = request & entry_valid[id] & entry_done[id];
    end
  end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ------------------------------------------------------------------
// reorder_buffer : in-order retirement buffer with CDB capture/listen
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_ENTRY       = c_DEF_ROB_ENTRY,
  parameter int ARCH_ENTRY      = c_DEF_ARCH_ENTRY,
  parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
  parameter int LSN_PORTS       = c_DEF_LSN_PORTS,
  parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
  parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
  input  logic                                CLK,
  input  logic                                RSTN,
  input  logic                                rob_request,
  input  logic [ARCH_ENTRY_LOG2-1:0]          rob_arch_id,
  output logic                                rob_grant,
  output logic [ROB_ENTRY_LOG2-1:0]           rob_alias_id,
  input  logic                                wb_valid,
  input  logic [ROB_ENTRY_LOG2-1:0]           wb_id,
  input  logic [DATA_WIDTH-1:0]               wb_data,
  input  logic [LSN_PORTS-1:0]                lsn_request,
  input  logic [LSN_PORTS*ROB_ENTRY_LOG2-1:0] lsn_id,
  output logic [LSN_PORTS-1:0]                lsn_hit,
  output logic [LSN_PORTS*DATA_WIDTH-1:0]     lsn_data,
  output logic                                commit_valid,
  output logic [ROB_ENTRY_LOG2-1:0]           commit_alias,
  output logic                                arch_reg_wen,
  output logic [ARCH_ENTRY_LOG2-1:0]          arch_reg_rd,
  output logic [DATA_WIDTH-1:0]               arch_reg_wdata,
  input  logic                                flush,
  output logic                                rob_full,
  output logic                                rob_empty
);

  localparam logic [ROB_ENTRY_LOG2:0]    c_CNT_FULL = (ROB_ENTRY_LOG2+1)'(ROB_ENTRY);
  localparam logic [ROB_ENTRY_LOG2:0]    c_CNT_ONE  = 1;
  localparam logic [ROB_ENTRY_LOG2-1:0]  c_IDX_ONE  = 1;
  localparam logic [ARCH_ENTRY_LOG2-1:0] c_ARCH_X0  = ARCH_ENTRY_LOG2'(c_X0_IDX);

  logic [c_FLAG_W-1:0]        r_flags [ROB_ENTRY];
  logic [ARCH_ENTRY_LOG2-1:0] r_arch  [ROB_ENTRY];
  logic [DATA_WIDTH-1:0]      r_data  [ROB_ENTRY];
  logic [ROB_ENTRY_LOG2-1:0]  r_head;
  logic [ROB_ENTRY_LOG2-1:0]  r_tail;
  logic [ROB_ENTRY_LOG2:0]    r_count;

  logic                          w_wb_hit;
  logic [ROB_ENTRY-1:0]          w_valid_vec;
  logic [ROB_ENTRY-1:0]          w_done_vec;
  logic [ROB_ENTRY*DATA_WIDTH-1:0] w_data_flat;

  assign rob_full     = (r_count == c_CNT_FULL);
  assign rob_empty    = (r_count == '0);
  assign rob_grant    = rob_request & ~rob_full & ~flush;
  assign rob_alias_id = r_tail;
  assign w_wb_hit     = wb_valid & r_flags[wb_id][c_FLAG_VALID];

  // Retirement reads stored state only; a same-cycle writeback lands next cycle
  assign commit_valid   = r_flags[r_head][c_FLAG_VALID] & r_flags[r_head][c_FLAG_DONE] & ~flush;
  assign commit_alias   = commit_valid ? r_head : '0;
  assign arch_reg_rd    = commit_valid ? r_arch[r_head] : '0;
  assign arch_reg_wdata = commit_valid ? r_data[r_head] : '0;
  assign arch_reg_wen   = commit_valid & (r_arch[r_head] != c_ARCH_X0);

  always_comb begin
    w_valid_vec = '0;
    w_done_vec  = '0;
    w_data_flat = '0;
    for (int i = 0; i < ROB_ENTRY; i++) begin
      w_valid_vec[i] = r_flags[i][c_FLAG_VALID];
      w_done_vec[i]  = r_flags[i][c_FLAG_DONE];
      w_data_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_data[i];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_ENTRY; i++) begin
        r_flags[i] <= '0;
        r_arch[i]  <= '0;
        r_data[i]  <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_ENTRY; i++) begin
        r_flags[i] <= '0;
      end
    end else begin
      if (w_wb_hit) begin
        r_flags[wb_id][c_FLAG_DONE] <= 1'b1;
        r_data[wb_id]               <= wb_data;
      end
      if (commit_valid) begin
        r_flags[r_head] <= '0;
        r_head          <= r_head + c_IDX_ONE;
      end
      // Grant only when not full, so the tail slot never aliases the head being retired
      if (rob_grant) begin
        r_flags[r_tail]               <= '0;
        r_flags[r_tail][c_FLAG_VALID] <= 1'b1;
        r_arch[r_tail]                <= rob_arch_id;
        r_tail                        <= r_tail + c_IDX_ONE;
      end
      case ({rob_grant, commit_valid})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar p = 0; p < LSN_PORTS; p++) begin : g_lsn
    rob_lsn_port #(
      .ROB_ENTRY      (ROB_ENTRY),
      .DATA_WIDTH     (DATA_WIDTH),
      .ROB_ENTRY_LOG2 (ROB_ENTRY_LOG2)
    ) u_lsn_port (
      .request     (lsn_request[p]),
      .id          (lsn_id[p*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]),
      .wb_valid    (wb_valid),
      .wb_id       (wb_id),
      .wb_data     (wb_data),
      .entry_valid (w_valid_vec),
      .entry_done  (w_done_vec),
      .entry_data  (w_data_flat),
      .hit         (lsn_hit[p]),
      .data        (lsn_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ------------------------------------------------------------------
// tb_reorder_buffer : scoreboard bench against a queue-based ROB model
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_reorder_buffer;
  localparam int N  = 4;
  localparam int LW = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int P  = 4;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          rob_request;
  logic [AW-1:0] rob_arch_id;
  logic          rob_grant;
  logic [LW-1:0] rob_alias_id;
  logic          wb_valid;
  logic [LW-1:0] wb_id;
  logic [DW-1:0] wb_data;
  logic [P-1:0]  lsn_request;
  logic [P*LW-1:0] lsn_id;
  logic [P-1:0]  lsn_hit;
  logic [P*DW-1:0] lsn_data;
  logic          commit_valid;
  logic [LW-1:0] commit_alias;
  logic          arch_reg_wen;
  logic [AW-1:0] arch_reg_rd;
  logic [DW-1:0] arch_reg_wdata;
  logic          flush;
  logic          rob_full;
  logic          rob_empty;

  reorder_buffer dut (
    .CLK(CLK), .RSTN(RSTN),
    .rob_request(rob_request), .rob_arch_id(rob_arch_id),
    .rob_grant(rob_grant), .rob_alias_id(rob_alias_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .lsn_request(lsn_request), .lsn_id(lsn_id),
    .lsn_hit(lsn_hit), .lsn_data(lsn_data),
    .commit_valid(commit_valid), .commit_alias(commit_alias),
    .arch_reg_wen(arch_reg_wen), .arch_reg_rd(arch_reg_rd),
    .arch_reg_wdata(arch_reg_wdata),
    .flush(flush), .rob_full(rob_full), .rob_empty(rob_empty)
  );

  always #5 CLK = ~CLK;

  // Reference model: the in-flight window as a program-order queue
  typedef struct {
    int          tag;
    int          arch;
    bit          done;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          tag;
    int          arch;
    logic [31:0] data;
  } cexp_t;

  ent_t  rob_q[$];
  int    m_tail;
  int    grant_q[$];
  cexp_t commit_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(int tag);
    foreach (rob_q[i]) if (rob_q[i].tag == tag) return i;
    return -1;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a grant or commit
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTN && rob_grant) begin
        if (grant_q.size() == 0) chk("unexpected_grant", 1, 0);
        else chk("grant_alias", rob_alias_id, grant_q.pop_front());
      end
      if (RSTN && commit_valid) begin
        if (commit_q.size() == 0) chk("unexpected_commit", 1, 0);
        else begin
          cexp_t c;
          c = commit_q.pop_front();
          chk("commit_alias", commit_alias, c.tag);
          chk("arch_reg_rd", arch_reg_rd, c.arch);
          chk("arch_reg_wdata", arch_reg_wdata, c.data);
          chk("arch_reg_wen", arch_reg_wen, c.arch != 0);
        end
      end
    end
  end

  task automatic cycle(bit req, int arch, bit wbv, int wbid, logic [31:0] wbd,
                       logic [P-1:0] lreq, logic [P*LW-1:0] lid, bit fl);
    bit exp_grant, exp_commit, ehit;
    int idx, li;
    logic [31:0] edata;
    @(posedge CLK); #1;
    rob_request = req;  rob_arch_id = AW'(arch);
    wb_valid = wbv;     wb_id = LW'(wbid);  wb_data = wbd;
    lsn_request = lreq; lsn_id = lid;       flush = fl;

    exp_grant  = req && (rob_q.size() < N) && !fl;
    exp_commit = !fl && (rob_q.size() > 0) && rob_q[0].done;
    if (exp_grant) grant_q.push_back(m_tail);
    if (exp_commit) commit_q.push_back('{rob_q[0].tag, rob_q[0].arch, rob_q[0].data});
    #1;
    chk("rob_grant", rob_grant, exp_grant);
    chk("commit_valid", commit_valid, exp_commit);
    chk("rob_full", rob_full, rob_q.size() == N);
    chk("rob_empty", rob_empty, rob_q.size() == 0);
    chk("rob_alias_id", rob_alias_id, m_tail);
    for (int p = 0; p < P; p++) begin
      li  = int'(lid[p*LW +: LW]);
      idx = find(li);
      ehit = 1'b0; edata = '0;
      if (wbv && wbid == li && idx >= 0) begin
        ehit = lreq[p]; edata = wbd;
      end else if (idx >= 0) begin
        ehit = lreq[p] && rob_q[idx].done; edata = rob_q[idx].data;
      end
      chk($sformatf("lsn_hit%0d", p), lsn_hit[p], ehit);
      if (ehit) chk($sformatf("lsn_data%0d", p), lsn_data[p*DW +: DW], edata);
    end

    if (fl) begin
      rob_q.delete();
      m_tail = 0;
    end else begin
      idx = find(wbid);
      if (wbv && idx >= 0) begin
        rob_q[idx].done = 1'b1;
        rob_q[idx].data = wbd;
      end
      if (exp_commit) void'(rob_q.pop_front());
      if (exp_grant) begin
        rob_q.push_back('{m_tail, arch, 1'b0, 32'h0});
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_empty"}, rob_empty, 1);
    chk({tag, "_full"}, rob_full, 0);
    chk({tag, "_commit"}, commit_valid, 0);
    chk({tag, "_wen"}, arch_reg_wen, 0);
    chk({tag, "_rd"}, arch_reg_rd, 0);
    chk({tag, "_wdata"}, arch_reg_wdata, 0);
    chk({tag, "_alias"}, rob_alias_id, 0);
  endtask

  initial begin
    RSTN = 1'b0;
    rob_request = 0; rob_arch_id = '0; wb_valid = 0; wb_id = '0; wb_data = '0;
    lsn_request = '0; lsn_id = '0; flush = 0;
    m_tail = 0;
    repeat (3) @(negedge CLK);
    #1;
    check_reset_state("reset");
    chk("reset_lsn_hit", lsn_hit, 0);
    @(negedge CLK); RSTN = 1'b1;

    // Fill, then a fifth request against a full buffer
    for (int a = 1; a <= 5; a++) cycle(1, a, 0, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 2, 32'hAA, '0, '0, 0);
    cycle(0, 0, 1, 0, 32'h11, '0, '0, 0);
    idle();
    cycle(1, 6, 0, 0, 0, '0, '0, 0);
    // Listen with same-cycle bypass, then from storage, and on an un-done entry
    cycle(0, 0, 1, 1, 32'h55, 4'b0001, 8'b11_00_11_01, 0);
    cycle(1, 7, 0, 0, 0, 4'b0011, 8'b00_00_11_01, 0);
    cycle(1, 7, 0, 0, 0, '0, '0, 0);
    // Flush together with a request and a writeback
    cycle(1, 8, 1, 3, 32'h99, 4'b1111, 8'b11_10_01_00, 1);
    // x0 destination never writes the register file
    cycle(1, 0, 0, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 0, 32'h77, '0, '0, 0);
    idle();
    idle();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge CLK); #1;
        RSTN = 1'b0;
        rob_request = 0; wb_valid = 0; lsn_request = '0; flush = 0;
        #1;
        check_reset_state("midreset");
        rob_q.delete(); m_tail = 0;
        grant_q.delete(); commit_q.delete();
        @(negedge CLK); RSTN = 1'b1;
      end
      cycle(($urandom_range(99) < 60), int'($urandom_range(AW'(31))),
            ($urandom_range(99) < 50), int'($urandom_range(N-1)), $urandom,
            P'($urandom), (P*LW)'($urandom), ($urandom_range(99) < 2));
    end
    rob_request = 0; wb_valid = 0; flush = 0; lsn_request = '0;
    @(negedge CLK); #1;
    chk("grant_q_drained", grant_q.size(), 0);
    chk("commit_q_drained", commit_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
